// File: rtl/move_history.sv
// -----------------------------------------------------------------------------
// move_history
//
// Last-in-first-out record of every stone accepted onto the board. It services
// the undo button by popping the most recent move and asking the board memory
// to clear that cell through a req/ack handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   put_ok       one-cycle pulse: board accepted a stone
//   put_pos      cell index of the accepted stone (row*10 + col)
//   put_color    colour of the accepted stone (1 = white, 0 = black)
//   undo         raw undo button level (rising edge detected internally)
//   clear_ack    board has cleared the requested cell
//   clear_req    request to clear cell clear_pos, held until acknowledged
//   clear_pos    cell to clear, stable while clear_req=1
//   clear_color  colour of the stone being removed
//   undo_done    one-cycle pulse when a pop completes
//   count        number of stored moves
//   last_pos     top-of-stack position, 0 when empty
//   last_valid   1 when count > 0
//   busy         1 whenever a pop is in progress
//   overflow     sticky: a push was attempted while the stack was full
// -----------------------------------------------------------------------------
module move_history #(
    parameter int DEPTH   = 100,
    parameter int POS_W   = 8,
    parameter int COUNT_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               put_ok,
    input  logic [POS_W-1:0]   put_pos,
    input  logic               put_color,
    input  logic               undo,
    input  logic               clear_ack,
    output logic               clear_req,
    output logic [POS_W-1:0]   clear_pos,
    output logic               clear_color,
    output logic               undo_done,
    output logic [COUNT_W-1:0] count,
    output logic [POS_W-1:0]   last_pos,
    output logic               last_valid,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_POP  = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] ONE_C   = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] TWO_C   = COUNT_W'(2);

    // Each entry is {colour, position}; validity is defined by count_q only.
    logic [POS_W:0]       mem_q [DEPTH];

    state_t               state_q,       state_d;
    logic [COUNT_W-1:0]   count_q,       count_d;
    logic                 undo_prev_q;
    logic [POS_W-1:0]     clear_pos_q,   clear_pos_d;
    logic                 clear_color_q, clear_color_d;
    logic [POS_W-1:0]     last_pos_q,    last_pos_d;
    logic                 last_valid_q,  last_valid_d;
    logic                 overflow_q,    overflow_d;

    logic                 push_en;
    logic                 undo_edge;
    logic [COUNT_W-1:0]   top_idx;
    logic [COUNT_W-1:0]   below_idx;
    logic [POS_W:0]       top_entry;
    logic [POS_W:0]       below_entry;

    assign undo_edge = undo & ~undo_prev_q;

    // Read indices are clamped so an empty or single-entry stack never
    // addresses outside the array; the results are only used when valid.
    assign top_idx     = (count_q >= ONE_C) ? (count_q - ONE_C) : '0;
    assign below_idx   = (count_q >= TWO_C) ? (count_q - TWO_C) : '0;
    assign top_entry   = mem_q[top_idx];
    assign below_entry = mem_q[below_idx];

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        clear_pos_d   = clear_pos_q;
        clear_color_d = clear_color_q;
        last_pos_d    = last_pos_q;
        last_valid_d  = last_valid_q;
        overflow_d    = overflow_q;
        push_en       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A push in the same cycle as an undo edge wins; the edge is lost.
                if (put_ok) begin
                    if (count_q < DEPTH_C) begin
                        push_en      = 1'b1;
                        count_d      = count_q + ONE_C;
                        last_pos_d   = put_pos;
                        last_valid_d = 1'b1;
                    end else begin
                        overflow_d   = 1'b1;
                    end
                end else if (undo_edge && (count_q != '0)) begin
                    clear_pos_d   = top_entry[POS_W-1:0];
                    clear_color_d = top_entry[POS_W];
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                if (clear_ack) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                count_d = count_q - ONE_C;
                if (count_q > ONE_C) begin
                    last_pos_d   = below_entry[POS_W-1:0];
                    last_valid_d = 1'b1;
                end else begin
                    last_pos_d   = '0;
                    last_valid_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            undo_prev_q   <= 1'b0;
            clear_pos_q   <= '0;
            clear_color_q <= 1'b0;
            last_pos_q    <= '0;
            last_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            undo_prev_q   <= undo;
            clear_pos_q   <= clear_pos_d;
            clear_color_q <= clear_color_d;
            last_pos_q    <= last_pos_d;
            last_valid_q  <= last_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    // Stack storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[count_q] <= {put_color, put_pos};
        end
    end

    // Request and done pulse are decoded from state so that an asynchronous
    // reset drops clear_req immediately and can never leave a pending pulse.
    assign clear_req   = (state_q == S_REQ);
    assign undo_done   = (state_q == S_POP);
    assign busy        = (state_q != S_IDLE);
    assign clear_pos   = clear_pos_q;
    assign clear_color = clear_color_q;
    assign count       = count_q;
    assign last_pos    = last_pos_q;
    assign last_valid  = last_valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_move_history.sv
module tb_move_history;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       put_ok = 1'b0;
    logic [7:0] put_pos = 8'd0;
    logic       put_color = 1'b0;
    logic       undo = 1'b0;
    logic       clear_ack = 1'b0;
    logic       clear_req;
    logic [7:0] clear_pos;
    logic       clear_color;
    logic       undo_done;
    logic [6:0] count;
    logic [7:0] last_pos;
    logic       last_valid;
    logic       busy;
    logic       overflow;

    move_history #(.DEPTH(100), .POS_W(8), .COUNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .put_ok(put_ok), .put_pos(put_pos), .put_color(put_color),
        .undo(undo), .clear_ack(clear_ack),
        .clear_req(clear_req), .clear_pos(clear_pos), .clear_color(clear_color),
        .undo_done(undo_done), .count(count), .last_pos(last_pos),
        .last_valid(last_valid), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stack of accepted moves and scoreboard of expected clear requests.
    logic [8:0] model_q[$];
    logic [8:0] sb_q[$];

    // Board-side responder: acknowledges after ack_delay cycles of request.
    int   ack_delay = 1;
    logic ack_spurious = 1'b0;
    int   req_age = 0;
    always @(negedge clk) begin
        if (clear_req) req_age++;
        else           req_age = 0;
        clear_ack = ack_spurious | (clear_req && (req_age >= ack_delay));
    end

    // Monitor: pops the scoreboard on each new request, checks hold stability.
    int         n_req = 0;
    int         n_done = 0;
    logic       prev_req = 1'b0;
    logic [8:0] held = 9'd0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (clear_req && !prev_req) begin
            n_req++;
            check("req_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("clear_pos", 32'(clear_pos), 32'(e[7:0]));
                check("clear_color", 32'(clear_color), 32'(e[8]));
            end
            held = {clear_color, clear_pos};
        end else if (clear_req) begin
            check("clear_hold", 32'({clear_color, clear_pos}), 32'(held));
        end
        if (undo_done) begin
            n_done++;
            check("done_without_req", 32'(clear_req), 32'd0);
        end
        prev_req = clear_req;
    end

    typedef struct {
        logic       p_ok;
        logic [7:0] pos;
        logic       col;
        logic [6:0] e_count;
        logic [7:0] e_last;
        logic       e_valid;
    } vec_t;
    vec_t vecs[3];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            if (!busy) break;
            tick();
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_req();
        int k;
        for (k = 0; k < 20; k++) begin
            if (clear_req) break;
            tick();
        end
        check("req_timeout", 32'(clear_req), 32'd1);
    endtask

    task automatic press_undo(input int hold, input int dly);
        ack_delay = dly;
        tick();
        undo = 1'b1;
        if (model_q.size() != 0) sb_q.push_back(model_q.pop_back());
        repeat (hold) tick();
        undo = 1'b0;
        wait_idle();
    endtask

    task automatic push(input logic [7:0] p, input logic c);
        tick();
        put_ok = 1'b1; put_pos = p; put_color = c;
        if (model_q.size() < 100) model_q.push_back({c, p});
        tick();
        put_ok = 1'b0;
    endtask

    initial begin
        int r0;
        int d0;
        vecs[0] = '{1'b1, 8'd44, 1'b0, 7'd1, 8'd44, 1'b1};
        vecs[1] = '{1'b1, 8'd45, 1'b1, 7'd2, 8'd45, 1'b1};
        vecs[2] = '{1'b0, 8'd99, 1'b1, 7'd2, 8'd45, 1'b1};

        // Reset state
        repeat (2) tick();
        check("rst_clear_req", 32'(clear_req), 32'd0);
        check("rst_clear_pos", 32'(clear_pos), 32'd0);
        check("rst_undo_done", 32'(undo_done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_last_pos", 32'(last_pos), 32'd0);
        check("rst_last_valid", 32'(last_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;

        // Table-driven pushes
        for (int i = 0; i < 3; i++) begin
            tick();
            put_ok = vecs[i].p_ok; put_pos = vecs[i].pos; put_color = vecs[i].col;
            if (vecs[i].p_ok) model_q.push_back({vecs[i].col, vecs[i].pos});
            tick();
            put_ok = 1'b0;
            check("vec_count", 32'(count), 32'(vecs[i].e_count));
            check("vec_last_pos", 32'(last_pos), 32'(vecs[i].e_last));
            check("vec_last_valid", 32'(last_valid), 32'(vecs[i].e_valid));
            check("vec_busy", 32'(busy), 32'd0);
            check("vec_overflow", 32'(overflow), 32'd0);
        end

        // Held undo, ack three cycles after the request: exactly one pop
        r0 = n_req; d0 = n_done;
        press_undo(10, 3);
        repeat (3) tick();
        check("held_req_count", 32'(n_req - r0), 32'd1);
        check("held_done_count", 32'(n_done - d0), 32'd1);
        check("held_count", 32'(count), 32'd1);
        check("held_last_pos", 32'(last_pos), 32'd44);

        // Acknowledge with no request outstanding is ignored
        r0 = n_req;
        ack_spurious = 1'b1;
        repeat (4) tick();
        ack_spurious = 1'b0;
        tick();
        check("spur_count", 32'(count), 32'd1);
        check("spur_req", 32'(n_req - r0), 32'd0);

        // Undo latency with immediate ack
        ack_delay = 1;
        tick();
        undo = 1'b1;
        sb_q.push_back(model_q.pop_back());
        tick();
        undo = 1'b0;
        check("lat_req_t1", 32'(clear_req), 32'd1);
        check("lat_count_t1", 32'(count), 32'd1);
        tick();
        check("lat_done_t2", 32'(undo_done), 32'd1);
        check("lat_req_t2", 32'(clear_req), 32'd0);
        tick();
        check("lat_busy_t3", 32'(busy), 32'd0);
        check("lat_count_t3", 32'(count), 32'd0);
        check("lat_last_pos_t3", 32'(last_pos), 32'd0);
        check("lat_valid_t3", 32'(last_valid), 32'd0);

        // Undo on an empty stack
        r0 = n_req; d0 = n_done;
        tick();
        undo = 1'b1;
        tick();
        undo = 1'b0;
        repeat (4) tick();
        check("empty_req", 32'(n_req - r0), 32'd0);
        check("empty_done", 32'(n_done - d0), 32'd0);
        check("empty_count", 32'(count), 32'd0);

        // Fill to capacity, then one push too many
        for (int i = 0; i < 100; i++) begin
            tick();
            put_ok = 1'b1; put_pos = 8'(i); put_color = 1'(i % 2);
            model_q.push_back({1'(i % 2), 8'(i)});
        end
        tick();
        put_ok = 1'b1; put_pos = 8'd7; put_color = 1'b0;
        tick();
        put_ok = 1'b0;
        check("full_count", 32'(count), 32'd100);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_last_pos", 32'(last_pos), 32'd99);
        press_undo(2, 1);
        tick();
        check("full_pop_overflow", 32'(overflow), 32'd1);
        check("full_pop_count", 32'(count), 32'd99);
        check("full_pop_last_pos", 32'(last_pos), 32'd98);

        // Fresh start: push coinciding with undo edge
        tick();
        rst = 1'b0;
        model_q.delete();
        tick();
        rst = 1'b1;
        check("rst2_overflow", 32'(overflow), 32'd0);
        push(8'd1, 1'b0);
        push(8'd2, 1'b1);
        push(8'd3, 1'b0);
        r0 = n_req;
        tick();
        put_ok = 1'b1; put_pos = 8'd12; put_color = 1'b1; undo = 1'b1;
        model_q.push_back({1'b1, 8'd12});
        tick();
        put_ok = 1'b0;
        repeat (2) tick();
        undo = 1'b0;
        tick();
        check("coinc_count", 32'(count), 32'd4);
        check("coinc_last_pos", 32'(last_pos), 32'd12);
        check("coinc_req", 32'(n_req - r0), 32'd0);

        // put_ok during REQ is dropped
        d0 = n_done;
        ack_delay = 5;
        tick();
        undo = 1'b1;
        sb_q.push_back(model_q.pop_back());
        wait_req();
        put_ok = 1'b1; put_pos = 8'd50; put_color = 1'b0;
        tick();
        put_ok = 1'b0; undo = 1'b0;
        wait_idle();
        tick();
        check("reqput_count", 32'(count), 32'd3);
        check("reqput_last_pos", 32'(last_pos), 32'd3);
        check("reqput_done", 32'(n_done - d0), 32'd1);

        // Reset while a request is outstanding
        ack_delay = 1000;
        tick();
        undo = 1'b1;
        sb_q.push_back(model_q.pop_back());
        wait_req();
        tick();
        #2 rst = 1'b0;
        #1;
        check("arst_clear_req", 32'(clear_req), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(last_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        model_q.delete();
        d0 = n_done;
        tick();
        rst = 1'b1; undo = 1'b0; ack_delay = 1;
        repeat (5) tick();
        check("arst_no_done", 32'(n_done - d0), 32'd0);
        check("arst_req_after", 32'(clear_req), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/move_history.md
# move_history

Records every stone accepted onto the board as a last-in-first-out stack of (position, colour) entries and services the player's undo button. An undo pops the most recent move and issues a clear-request handshake to the board memory stage. The block sits between the cursor/put control and the board memory: it consumes the board's "stone placed" pulse and produces cell-clear requests. It also exposes the top-of-stack so that the display and win logic can highlight or re-evaluate the last move.

## Interface
- DEPTH, 100: number of stack entries (one per board cell, 10x10 playable grid).
- POS_W, 8: width of a cell index (row*10 + col).
- COUNT_W, 7: width of the occupancy counter; must satisfy 2^COUNT_W > DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- put_ok  in  1  one-cycle pulse: the board accepted a stone this cycle.
- put_pos  in  POS_W  cell index of the accepted stone; valid when put_ok=1.
- put_color  in  1  colour of the accepted stone (1 = white 2'b11, 0 = black 2'b10).
- undo  in  1  raw undo button level; the block detects its rising edge internally.
- clear_ack  in  1  board has cleared the requested cell; sampled only while clear_req=1.
- clear_req  out  1  request to clear cell clear_pos; held until acknowledged.
- clear_pos  out  POS_W  cell to clear; stable while clear_req=1.
- clear_color  out  1  colour of the stone being removed; stable while clear_req=1.
- undo_done  out  1  one-cycle pulse when a pop completes; the board uses it to step its turn counter back.
- count  out  COUNT_W  number of stored moves.
- last_pos  out  POS_W  top-of-stack position; 0 when empty.
- last_valid  out  1  1 when count>0.
- busy  out  1  1 in any state other than IDLE; upstream must not issue put_ok while busy.
- overflow  out  1  sticky: set when a push is attempted while full.

## Operation
- Storage: DEPTH x (POS_W+1) register array. Entry i holds move i+1. The array is not cleared by reset; count defines validity.
- Edge detect: undo_prev is registered every cycle. undo_edge = undo & ~undo_prev.
- FSM states: IDLE, REQ, POP.
  - IDLE, put_ok=1:
    - If count<DEPTH: write {put_color, put_pos} to entry[count] and increment count.
    - If count==DEPTH: no write, overflow <= 1.
    - Any undo_edge in the same cycle is discarded (push wins).
  - IDLE, put_ok=0, undo_edge=1:
    - If count>0: load clear_pos/clear_color from entry[count-1], set clear_req=1, go to REQ.
    - If count==0: ignore; no request, no pulse.
  - REQ: hold clear_req, clear_pos and clear_color. When clear_ack=1 is sampled, drop clear_req and go to POP.
  - POP (exactly one cycle): decrement count, pulse undo_done=1, go to IDLE.
- In REQ and POP, put_ok is dropped (no write, no overflow), and undo edges are discarded.
- last_pos and last_valid are registered and updated on the same edge as count. After a push, last_pos=put_pos. After a pop, last_pos=entry[count-2], or 0 if the stack is now empty.
- Arithmetic: count changes only by ±1 and never wraps. Pushes are blocked at DEPTH and pops are blocked at 0.

## Timing
- Reset (rst=0, asynchronous) values:
  - state=IDLE, count=0, undo_prev=0.
  - clear_req=0, clear_pos=0, clear_color=0, undo_done=0.
  - last_pos=0, last_valid=0, busy=0, overflow=0.
- Reset asserted mid-REQ: clear_req drops immediately (asynchronously); no undo_done pulse follows.
- Push latency: put_ok at edge t gives count/last_pos/last_valid updated after edge t (visible in cycle t+1).
- Undo latency (ack tied to 1):
  - undo_edge sampled at edge t: clear_req=1 in cycle t+1.
  - ack sampled at edge t+1: POP in cycle t+2, with undo_done=1 and clear_req=0.
  - count decremented and IDLE after edge t+2.
  - Minimum 3 cycles from button edge to next accepted push.
- Handshake: clear_req stays asserted and clear_pos stays stable for any number of cycles until clear_ack=1. clear_ack while clear_req=0 is ignored.
- A held undo button produces exactly one pop. Release and re-press are required for the next one.
- busy is combinationally equal to (state != IDLE).

## Test plan
- Reset, then pushes (put_ok with pos 44 black, then 45 white): count=2, last_pos=45, last_valid=1, busy=0, overflow=0.
- From that state, raise undo and hold it for 10 cycles, with clear_ack returned 3 cycles after clear_req: one clear_req with clear_pos=45, clear_color=1; then one undo_done pulse; count=1, last_pos=44. No second request.
- Undo with count=0: clear_req stays 0, undo_done stays 0, count stays 0.
- 100 pushes, then a 101st put_ok (pos 7): count=100, overflow=1 and stays 1; entry 100 is unchanged. Next undo returns the 100th position.
- put_ok (pos 12) in the same cycle as an undo rising edge, in IDLE with count=3: count=4, last_pos=12, no clear_req. A put_ok issued during REQ is dropped, and count is unchanged.
- rst low while clear_req=1: clear_req=0 immediately, count=0, last_valid=0. No undo_done after rst is released.
